// File: rtl/operand_loader.sv
// operand_loader: collects operand pairs from a valid/ready stream and writes
// them into the shared operand memory (A at even, B at odd addresses). When the
// memory holds a full frame it pulses mul_start, then blocks input until the
// multiplier controller reports mul_done.
module operand_loader #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mul_start,
   input  logic              mul_done,
   output logic              busy
);

   localparam int unsigned     K_W    = ADDR_W - 1;
   localparam logic [K_W-1:0] K_LAST = '1;
   localparam logic [K_W-1:0] K_ONE  = K_W'(1);

   typedef enum logic [2:0] {
      COLLECT,
      WR_A,
      WR_B,
      KICK,
      WAIT
   } state_t;

   state_t             state_q;
   logic [K_W-1:0]     k_q;
   logic [DATA_W-1:0]  a_q;
   logic [DATA_W-1:0]  b_q;

   // Output registers hold the decode of the state being entered, so every
   // output is a pure function of the current state.
   logic               ready_q;
   logic               we_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q;
   logic               start_q;
   logic               busy_q;

   // State machine, pair counter, operand capture and registered output decode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= COLLECT;
         k_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ready_q <= 1'b1;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         start_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            COLLECT: begin
               if (in_valid) begin
                  a_q     <= in_a;
                  b_q     <= in_b;
                  state_q <= WR_A;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
                  we_q    <= 1'b1;
                  addr_q  <= {k_q, 1'b0};
                  wdata_q <= in_a;
               end
            end
            WR_A: begin
               state_q <= WR_B;
               addr_q  <= {k_q, 1'b1};
               wdata_q <= b_q;
            end
            WR_B: begin
               we_q    <= 1'b0;
               addr_q  <= '0;
               wdata_q <= '0;
               if (k_q == K_LAST) begin
                  k_q     <= '0;
                  state_q <= KICK;
                  start_q <= 1'b1;
               end else begin
                  k_q     <= k_q + K_ONE;
                  state_q <= COLLECT;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            KICK: begin
               start_q <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (mul_done) begin
                  state_q <= COLLECT;
                  ready_q <= 1'b1;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= COLLECT;
               k_q     <= '0;
               ready_q <= 1'b1;
               we_q    <= 1'b0;
               addr_q  <= '0;
               wdata_q <= '0;
               start_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Every output is forced low during a reset cycle so an interrupted write
   // or start never reaches the memory or the controller.
   assign in_ready  = ready_q & rst;
   assign mem_we    = we_q & rst;
   assign mem_addr  = addr_q & {ADDR_W{rst}};
   assign mem_wdata = wdata_q & {DATA_W{rst}};
   assign mul_start = start_q & rst;
   assign busy      = busy_q & rst;

endmodule

// File: tb/tb_operand_loader.sv
// tb_operand_loader: randomized/directed stimulus with a queue-based
// reference model; a negedge monitor pops expected writes and start pulses.
module tb_operand_loader;

   localparam int unsigned DW = 16;
   localparam int unsigned AW = 3;
   localparam int unsigned NP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_a;
   logic [DW-1:0] in_b;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mul_start;
   logic          mul_done;
   logic          busy;

   operand_loader #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mul_start (mul_start),
      .mul_done  (mul_done),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int unsigned n_chk  = 0;
   int unsigned n_pass = 0;

   typedef struct {
      int unsigned   cyc;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t         exp_wr[$];
   int unsigned exp_start[$];
   int unsigned slot          = 0;
   bit          accepted      = 1'b0;
   bit          track_spacing = 1'b0;
   int unsigned last_acc      = 0;
   int unsigned starts_seen   = 0;
   wr_t         e;
   int unsigned s;

   task automatic chk(input bit ok, input string name, input longint act, input longint exp);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor and reference model: each accepted pair lands at pair slot
   // (count mod NP); A one cycle after acceptance, B two, and a start three
   // cycles after the pair that completes a frame.
   always @(negedge clk) begin
      if (!rst) begin
         exp_wr.delete();
         exp_start.delete();
         slot = 0;
      end else begin
         while (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
            e = exp_wr.pop_front();
            chk(1'b0, "missing_write_cycle", cyc, e.cyc);
         end
         while (exp_start.size() > 0 && exp_start[0] < cyc) begin
            s = exp_start.pop_front();
            chk(1'b0, "missing_start_cycle", cyc, s);
         end
         if (mem_we) begin
            if (exp_wr.size() == 0) begin
               chk(1'b0, "unexpected_write_addr", mem_addr, 0);
            end else begin
               e = exp_wr.pop_front();
               chk(e.cyc == cyc, "write_cycle", cyc, e.cyc);
               chk(mem_addr == e.addr, "write_addr", mem_addr, e.addr);
               chk(mem_wdata == e.data, "write_data", mem_wdata, e.data);
            end
         end else begin
            chk({mem_addr, mem_wdata} == '0, "idle_bus_zero", {mem_addr, mem_wdata}, 0);
         end
         if (mul_start) begin
            starts_seen++;
            if (exp_start.size() == 0) begin
               chk(1'b0, "unexpected_start_cycle", cyc, 0);
            end else begin
               s = exp_start.pop_front();
               chk(s == cyc, "start_cycle", cyc, s);
            end
         end
         chk(busy == !in_ready, "busy_vs_ready", busy, !in_ready);
         if (in_valid && in_ready) begin
            if (track_spacing && slot != 0)
               chk(cyc - last_acc == 3, "accept_spacing", cyc - last_acc, 3);
            last_acc = cyc;
            exp_wr.push_back('{cyc: cyc + 1, addr: AW'(2 * slot),     data: in_a});
            exp_wr.push_back('{cyc: cyc + 2, addr: AW'(2 * slot + 1), data: in_b});
            if (slot == NP - 1) exp_start.push_back(cyc + 3);
            slot     = (slot + 1) % NP;
            accepted = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a pair and hold it until accepted; returns in the WR_A cycle.
   task automatic send_pair(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit bubbly);
      int unsigned n = 0;
      in_a = a;
      in_b = b;
      forever begin
         if (bubbly) in_valid = 1'($urandom_range(0, 1));
         else        in_valid = 1'b1;
         tick();
         if (accepted) begin
            accepted = 1'b0;
            break;
         end
         n++;
         if (n > 200) begin
            chk(1'b0, "accept_timeout_cycles", n, 200);
            break;
         end
      end
   endtask

   task automatic pulse_done();
      mul_done = 1'b1;
      tick();
      mul_done = 1'b0;
   endtask

   task automatic finish_frame();
      in_valid = 1'b0;
      repeat (3 + $urandom_range(0, 4)) tick();
      pulse_done();
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      rst      = 1'b0;
      in_valid = 1'b1;
      in_a     = 16'h0011;
      in_b     = 16'h0022;
      mul_done = 1'b0;

      // Reset held for three edges with a pending pair.
      repeat (3) begin
         @(negedge clk);
         chk({in_ready, mem_we, mem_addr, mem_wdata, mul_start, busy} == '0, "reset_outputs",
             {in_ready, mem_we, mem_addr, mem_wdata, mul_start, busy}, 0);
      end
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk(in_ready == 1'b1, "ready_after_reset", in_ready, 1);
      chk(mem_we == 1'b0, "no_write_after_reset", mem_we, 0);

      // Full frame with in_valid held high.
      track_spacing = 1'b1;
      send_pair(16'h0011, 16'h0022, 1'b0);
      send_pair(16'h0033, 16'h0044, 1'b0);
      send_pair(16'h0055, 16'h0066, 1'b0);
      send_pair(16'h0077, 16'h0088, 1'b0);
      track_spacing = 1'b0;

      // Stall in WAIT with a pending pair.
      in_a     = 16'hAAAA;
      in_b     = 16'hBBBB;
      in_valid = 1'b1;
      repeat (2) tick();
      repeat (20) begin
         @(negedge clk);
         chk(!in_ready && !mem_we && busy, "stall_hold", {in_ready, mem_we, busy}, 3'b001);
      end
      tick();
      pulse_done();
      @(negedge clk);
      chk(in_ready == 1'b1, "ready_after_done", in_ready, 1);
      send_pair(16'hAAAA, 16'hBBBB, 1'b0);

      // Reset during WR_B of the third pair of a frame.
      send_pair(16'($urandom), 16'($urandom), 1'b0);
      send_pair(16'($urandom), 16'($urandom), 1'b0);
      in_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      repeat (NP) send_pair(16'($urandom), 16'($urandom), 1'b0);
      finish_frame();

      // Spurious mul_done in COLLECT, WR_A and KICK.
      in_valid = 1'b0;
      tick();
      pulse_done();
      send_pair(16'h1234, 16'h5678, 1'b0);
      pulse_done();
      send_pair(16'h9ABC, 16'hDEF0, 1'b0);
      send_pair(16'h0F0F, 16'hF0F0, 1'b0);
      send_pair(16'h1357, 16'h2468, 1'b0);
      in_valid = 1'b0;
      tick();
      tick();
      pulse_done();
      repeat (5) begin
         @(negedge clk);
         chk(!in_ready && busy, "wait_holds_after_spurious", {in_ready, busy}, 2'b01);
      end
      tick();
      pulse_done();
      @(negedge clk);
      chk(in_ready == 1'b1, "ready_after_real_done", in_ready, 1);

      // Bubbly source over three frames.
      for (int f = 0; f < 3; f++) begin
         for (int p = 0; p < int'(NP); p++)
            send_pair(16'($urandom), 16'($urandom), 1'b1);
         finish_frame();
      end

      in_valid = 1'b0;
      repeat (5) tick();
      chk(exp_wr.size() == 0, "write_queue_drained", exp_wr.size(), 0);
      chk(exp_start.size() == 0, "start_queue_drained", exp_start.size(), 0);
      chk(starts_seen == 6, "start_pulse_count", starts_seen, 6);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/operand_loader.md
# operand_loader

Front-end writer for the approximate-multiplier datapath. It accepts operand pairs over a valid/ready stream and writes them into the shared operand memory, operand A at even addresses and operand B at odd addresses. Once the memory is full, it pulses `mul_start` to the multiplier controller. It then holds off new input until the controller reports `mul_done`, so memory the controller is still reading is never overwritten.

## Interface
- `DATA_W`, default 16: operand and memory word width.
- `ADDR_W`, default 4: operand-memory address width; memory holds NUM_PAIRS = 2^(ADDR_W-1) pairs.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  source has a pair on `in_a`/`in_b`.
- `in_ready`  out  1  loader accepts a pair this cycle.
- `in_a`  in  DATA_W  operand A.
- `in_b`  in  DATA_W  operand B.
- `mem_we`  out  1  operand-memory write enable.
- `mem_addr`  out  ADDR_W  write address.
- `mem_wdata`  out  DATA_W  write data.
- `mul_start`  out  1  one-cycle start pulse to the multiplier controller.
- `mul_done`  in  1  multiplier controller finished the whole memory.
- `busy`  out  1  high in every state except COLLECT.

## Operation
- Moore FSM; all outputs decode from state only. The FSM has five states, chained below:
  - **COLLECT:** `in_ready`=1. On `in_valid`&`in_ready`, capture `in_a` into `a_reg` and `in_b` into `b_reg`, then go to WR_A.
  - **WR_A:** `mem_we`=1, `mem_addr`={k,1'b0}, `mem_wdata`=`a_reg`. Go to WR_B.
  - **WR_B:** `mem_we`=1, `mem_addr`={k,1'b1}, `mem_wdata`=`b_reg`. If k==NUM_PAIRS-1, set k to 0 and go to KICK. Otherwise increment k and go to COLLECT.
  - **KICK:** `mul_start`=1 for exactly one cycle. Go to WAIT.
  - **WAIT:** hold until `mul_done`=1, then go to COLLECT.
- Pair counter k is ADDR_W-1 bits wide. It increments only in WR_B; the wrap from NUM_PAIRS-1 to 0 is the frame-complete condition.
- `a_reg`/`b_reg` load only on an accepted handshake. They are stable through WR_A and WR_B.
- In every state other than WR_A and WR_B: `mem_we`=0, and `mem_addr`/`mem_wdata` are 0.
- `mul_done` is ignored outside WAIT; no pending flag is kept.
- `in_valid` while `in_ready`=0: nothing is captured. The source must hold the data stable until accepted.
- `mul_start` is never re-asserted while in WAIT. Its single-cycle width satisfies the controller's requirement that start drops before it leaves its init state.

## Timing
- While `rst`=0 at a clock edge: state becomes COLLECT, k=0, `a_reg`=`b_reg`=0.
  - All outputs are 0 during a cycle in which `rst` is low; `in_ready` is gated by `rst`.
  - First `in_ready`=1 is the cycle after `rst` goes high.
- Pair accepted at edge t:
  - A is written in cycle t..t+1 (WR_A).
  - B is written in cycle t+1..t+2 (WR_B).
  - The next acceptance is possible at edge t+3.
- Throughput is one pair per 3 cycles.
- Last pair accepted at edge t: `mul_start` is high in cycle t+2..t+3, and `busy` is high from edge t onward.
- `mul_done` sampled high at edge u while in WAIT: `in_ready`=1 in the cycle after edge u.
- `mul_done` high in the same cycle as KICK is ignored.
- Reset mid-operation (any state, including mid-write or WAIT): the next cycle is COLLECT with k=0, and no write or start is issued.
  - Memory contents are not cleared.
  - A partially written pair is abandoned; the next accepted pair goes to addresses 0/1.
- A partial frame never triggers `mul_start`; only the wrap after pair NUM_PAIRS-1 does.

## Test plan
All scenarios use ADDR_W=3 (4 pairs) and DATA_W=16.
- **Reset:** hold `rst`=0 for 3 cycles with `in_valid`=1 -> all outputs 0; first cycle after release `in_ready`=1 with no write.
- **Full frame:** stream pairs (0x0011,0x0022), (0x0033,0x0044), (0x0055,0x0066), (0x0077,0x0088) with `in_valid` held high -> writes addr0=0x0011, addr1=0x0022, …, addr7=0x0088; acceptances 3 cycles apart; exactly one `mul_start` pulse, 2 cycles after the 4th acceptance.
- **Back-pressure/stall:** after the frame, keep `in_valid`=1 with 0xAAAA/0xBBBB and `mul_done`=0 for 20 cycles -> `in_ready`=0, `mem_we`=0, `busy`=1 throughout; pulse `mul_done` -> `in_ready`=1 next cycle, next pair written to addr0=0xAAAA and addr1=0xBBBB.
- **Spurious done:** pulse `mul_done` during COLLECT, WR_A and KICK -> no state change; WAIT is still entered and still waits for a later `mul_done`.
- **Bubbly source:** `in_valid` toggles randomly and `in_a` changes only after acceptance -> the memory image matches the accepted sequence; k wraps 3→0 exactly once per frame.
- **Reset mid-frame:** assert `rst`=0 during WR_B of pair 2 -> no `mul_start`; the next 4 pairs fill addresses 0..7 from scratch, followed by one `mul_start`.
